// File: rtl/noc_traffic_sequencer.sv
// Run controller for the NoC traffic bench: staggered PE enable ramp, completion and drain
// detection, global run statistics. Optional watchdog is compiled in by NOC_SEQ_WATCHDOG_EN.
module noc_traffic_sequencer #(
    parameter int X           = 4,
    parameter int Y           = 4,
    parameter int STAGGER     = 2,
    parameter int DRAIN_QUIET = 16,
    parameter int TIMEOUT     = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_go,
    input  logic [X*Y-1:0]   i_pe_done,
    input  logic [X*Y-1:0]   i_pe_rx_valid,
    output logic             o_start,
    output logic [X*Y-1:0]   o_enable_send,
    output logic             o_busy,
    output logic             o_finished,
    output logic             o_timeout,
    output logic [31:0]      o_cycle_count,
    output logic [31:0]      o_rx_total
);
    localparam int N  = X * Y;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int QW = $clog2(DRAIN_QUIET + 1);
    localparam bit ALL_AT_ONCE = (STAGGER == 0) || (N == 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RAMP   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_REPORT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t        state_r, state_next_s;
    logic [IW-1:0] pe_idx_r, pe_idx_s;
    logic [SW-1:0] stag_cnt_r, stag_cnt_s;
    logic [QW-1:0] quiet_cnt_r, quiet_cnt_s;
    logic          start_s, busy_s, finished_s, timeout_s;
    logic [N-1:0]  enable_s;
    logic [31:0]   cycle_count_s, rx_total_s;
    logic          run_phase_s, wd_hit_s, stag_last_s, rx_any_s, quiet_last_s;
    logic [32:0]   rx_sum_s;

    function automatic logic [31:0] popcount(input logic [N-1:0] v);
        logic [31:0] c;
        c = 32'd0;
        for (int i = 0; i < N; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

    assign run_phase_s  = (state_r == ST_RAMP) || (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign stag_last_s  = (stag_cnt_r == SW'(STAGGER - 1));
    assign quiet_last_s = (quiet_cnt_r == QW'(DRAIN_QUIET - 1));
    assign rx_any_s     = |i_pe_rx_valid;
    assign rx_sum_s     = {1'b0, o_rx_total} + {1'b0, popcount(i_pe_rx_valid)};

`ifdef NOC_SEQ_WATCHDOG_EN
    assign wd_hit_s = run_phase_s && (o_cycle_count == 32'(TIMEOUT - 1));
`else
    // Watchdog compiled out: constant-false, parameter still referenced.
    assign wd_hit_s = (TIMEOUT < 0);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the watchdog pre-empts every other busy-phase transition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (i_go) begin
                    state_next_s = ALL_AT_ONCE ? ST_RUN : ST_RAMP;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RAMP: begin
                if (wd_hit_s) begin
                    state_next_s = ST_REPORT;
                end else if (stag_last_s && (pe_idx_r == IW'(N - 1))) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_RAMP;
                end
            end
            ST_RUN: begin
                if (wd_hit_s) begin
                    state_next_s = ST_REPORT;
                end else if (&i_pe_done) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (wd_hit_s || (!rx_any_s && quiet_last_s)) begin
                    state_next_s = ST_REPORT;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_REPORT: state_next_s = ST_DONE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and run counters.
    always_comb begin
        start_s     = o_start;
        enable_s    = o_enable_send;
        timeout_s   = o_timeout;
        pe_idx_s    = pe_idx_r;
        stag_cnt_s  = stag_cnt_r;
        quiet_cnt_s = quiet_cnt_r;
        if (run_phase_s) begin
            rx_total_s    = rx_sum_s[32] ? 32'hFFFF_FFFF : rx_sum_s[31:0];
            cycle_count_s = wd_hit_s ? o_cycle_count : o_cycle_count + 32'd1;
        end else begin
            rx_total_s    = o_rx_total;
            cycle_count_s = o_cycle_count;
        end
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (i_go) begin
                    start_s       = 1'b1;
                    enable_s      = ALL_AT_ONCE ? {N{1'b1}} : N'(1'b1);
                    pe_idx_s      = IW'(1);
                    stag_cnt_s    = {SW{1'b0}};
                    cycle_count_s = 32'd0;
                    rx_total_s    = 32'd0;
                    timeout_s     = 1'b0;
                end else begin
                    start_s = o_start;
                end
            end
            ST_RAMP: begin
                if (stag_last_s) begin
                    enable_s[pe_idx_r] = 1'b1;
                    pe_idx_s           = pe_idx_r + IW'(1);
                    stag_cnt_s         = {SW{1'b0}};
                end else begin
                    stag_cnt_s = stag_cnt_r + SW'(1);
                end
            end
            ST_RUN:   quiet_cnt_s = {QW{1'b0}};
            ST_DRAIN: begin
                if (rx_any_s) begin
                    quiet_cnt_s = {QW{1'b0}};
                end else begin
                    quiet_cnt_s = quiet_cnt_r + QW'(1);
                end
            end
            default:  quiet_cnt_s = quiet_cnt_r;
        endcase
        if (state_next_s == ST_REPORT) begin
            start_s   = 1'b0;
            enable_s  = {N{1'b0}};
            timeout_s = o_timeout | wd_hit_s;
        end else begin
            timeout_s = timeout_s;
        end
        busy_s     = (state_next_s == ST_RAMP) || (state_next_s == ST_RUN) ||
                     (state_next_s == ST_DRAIN) || (state_next_s == ST_REPORT);
        finished_s = (state_next_s == ST_DONE);
    end

    // Output and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_start       <= 1'b0;
            o_enable_send <= {N{1'b0}};
            o_busy        <= 1'b0;
            o_finished    <= 1'b0;
            o_timeout     <= 1'b0;
            o_cycle_count <= 32'd0;
            o_rx_total    <= 32'd0;
            pe_idx_r      <= {IW{1'b0}};
            stag_cnt_r    <= {SW{1'b0}};
            quiet_cnt_r   <= {QW{1'b0}};
        end else begin
            o_start       <= start_s;
            o_enable_send <= enable_s;
            o_busy        <= busy_s;
            o_finished    <= finished_s;
            o_timeout     <= timeout_s;
            o_cycle_count <= cycle_count_s;
            o_rx_total    <= rx_total_s;
            pe_idx_r      <= pe_idx_s;
            stag_cnt_r    <= stag_cnt_s;
            quiet_cnt_r   <= quiet_cnt_s;
        end
    end

endmodule

// File: tb/tb_noc_traffic_sequencer.sv
// Bench for noc_traffic_sequencer: instance A (STAGGER=3) against a run-level model,
// instance B (STAGGER=0, DRAIN_QUIET=2, TIMEOUT=50) against a vector table and watchdog run.
module tb_noc_traffic_sequencer;
    localparam int NPE  = 4;
    localparam int S_A  = 3;
    localparam int DQ_A = 16;
    localparam int TO_A = 100000;
`ifdef NOC_SEQ_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    logic go_a, go_b;
    logic [NPE-1:0] done_a, rx_a, done_b, rx_b;
    logic start_a, busy_a, fin_a, to_a, start_b, busy_b, fin_b, to_b;
    logic [NPE-1:0] en_a, en_b;
    logic [31:0] cnt_a, rxt_a, cnt_b, rxt_b;

    int n_cmp = 0;
    int n_bad = 0;

    noc_traffic_sequencer #(.X(2), .Y(2), .STAGGER(S_A), .DRAIN_QUIET(DQ_A), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst(rst), .i_go(go_a), .i_pe_done(done_a), .i_pe_rx_valid(rx_a),
        .o_start(start_a), .o_enable_send(en_a), .o_busy(busy_a), .o_finished(fin_a),
        .o_timeout(to_a), .o_cycle_count(cnt_a), .o_rx_total(rxt_a));

    noc_traffic_sequencer #(.X(2), .Y(2), .STAGGER(0), .DRAIN_QUIET(2), .TIMEOUT(50)) dut_b (
        .clk(clk), .rst(rst), .i_go(go_b), .i_pe_done(done_b), .i_pe_rx_valid(rx_b),
        .o_start(start_b), .o_enable_send(en_b), .o_busy(busy_b), .o_finished(fin_b),
        .o_timeout(to_b), .o_cycle_count(cnt_b), .o_rx_total(rxt_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        go;
        logic [3:0]  done;
        logic [3:0]  rx;
        logic        start;
        logic [3:0]  en;
        logic        busy;
        logic        fin;
        logic [31:0] cnt;
        logic [31:0] rxt;
    } vec_t;
    vec_t tbl [14];

    // Run-level model of instance A: a run is active from go until drained/timed out.
    bit              m_run, m_drain, m_report, m_fin, m_to;
    int unsigned     m_t, m_quiet;
    longint unsigned m_rx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_drain = 1'b0; m_report = 1'b0; m_fin = 1'b0; m_to = 1'b0;
        m_t = 0; m_quiet = 0; m_rx = 0;
    endtask

    task automatic model_step();
        bit ramp_over;
        if (m_run) begin
            m_rx = m_rx + longint'($countones(rx_a));
            if (m_rx > 64'hFFFF_FFFF) m_rx = 64'hFFFF_FFFF;
            if (WD_ON && (m_t == TO_A - 1)) begin
                m_run = 1'b0; m_drain = 1'b0; m_report = 1'b1; m_to = 1'b1;
            end else begin
                ramp_over = (m_t >= (NPE - 1) * S_A);
                m_t = m_t + 1;
                if (m_drain) begin
                    if (rx_a != 4'h0) m_quiet = 0;
                    else m_quiet = m_quiet + 1;
                    if (m_quiet == DQ_A) begin
                        m_run = 1'b0; m_drain = 1'b0; m_report = 1'b1;
                    end
                end else if (ramp_over && (done_a == 4'hF)) begin
                    m_drain = 1'b1; m_quiet = 0;
                end
            end
        end else if (m_report) begin
            m_report = 1'b0; m_fin = 1'b1;
        end else if (go_a) begin
            m_run = 1'b1; m_drain = 1'b0; m_t = 0; m_rx = 0; m_to = 1'b0; m_fin = 1'b0;
        end
    endtask

    function automatic logic [3:0] model_en();
        logic [3:0] e;
        e = 4'h0;
        if (m_run) begin
            for (int k = 0; k < NPE; k++) begin
                if (k * S_A <= m_t) e[k] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check_a();
        chk("a_start", start_a, m_run);
        chk("a_enable", en_a, model_en());
        chk("a_busy", busy_a, m_run | m_report);
        chk("a_finished", fin_a, m_fin);
        chk("a_timeout", to_a, m_to);
        chk("a_cycle_count", cnt_a, m_t);
        chk("a_rx_total", rxt_a, m_rx[31:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_a();
    endtask

    initial begin
        rst = 1'b1;
        go_a = 1'b0; done_a = 4'h0; rx_a = 4'h0;
        go_b = 1'b0; done_b = 4'h0; rx_b = 4'h0;
        model_reset();
        //          go    done   rx     start  en     busy  fin   cnt    rxt
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 32'd0, 32'd0};
        tbl[1]  = '{1'b0, 4'h0, 4'h3, 1'b1, 4'hF, 1'b1, 1'b0, 32'd1, 32'd2};
        tbl[2]  = '{1'b0, 4'hF, 4'h1, 1'b1, 4'hF, 1'b1, 1'b0, 32'd2, 32'd3};
        tbl[3]  = '{1'b0, 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 32'd3, 32'd3};
        tbl[4]  = '{1'b0, 4'h0, 4'h4, 1'b1, 4'hF, 1'b1, 1'b0, 32'd4, 32'd4};
        tbl[5]  = '{1'b0, 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 32'd5, 32'd4};
        tbl[6]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 32'd6, 32'd4};
        tbl[7]  = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'd6, 32'd4};
        tbl[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'd6, 32'd4};
        tbl[9]  = '{1'b1, 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 32'd0, 32'd0};
        tbl[10] = '{1'b0, 4'hF, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 32'd1, 32'd0};
        tbl[11] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 32'd2, 32'd0};
        tbl[12] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 32'd3, 32'd0};
        tbl[13] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'd3, 32'd0};

        repeat (3) @(negedge clk);
        check_a();
        chk("b_rst_start", start_b, 1'b0);
        chk("b_rst_enable", en_b, 4'h0);
        chk("b_rst_finished", fin_b, 1'b0);
        rst = 1'b0;

        // Instance B vector table: all-at-once enable, short drain, REPORT/DONE go handling.
        for (int r = 0; r < 14; r++) begin
            go_b = tbl[r].go; done_b = tbl[r].done; rx_b = tbl[r].rx;
            tick();
            chk($sformatf("tbl%0d_start", r), start_b, tbl[r].start);
            chk($sformatf("tbl%0d_enable", r), en_b, tbl[r].en);
            chk($sformatf("tbl%0d_busy", r), busy_b, tbl[r].busy);
            chk($sformatf("tbl%0d_finished", r), fin_b, tbl[r].fin);
            chk($sformatf("tbl%0d_timeout", r), to_b, 1'b0);
            chk($sformatf("tbl%0d_cycles", r), cnt_b, tbl[r].cnt);
            chk($sformatf("tbl%0d_rx_total", r), rxt_b, tbl[r].rxt);
        end
        go_b = 1'b0; done_b = 4'h0; rx_b = 4'h0;

        // Instance A: staggered ramp with done ignored, rx in RUN, rx restarting the drain.
        go_a = 1'b1;
        tick();
        go_a = 1'b0;
        done_a = 4'hF;
        for (int j = 0; j <= 9; j++) begin
            logic [3:0] exp_en;
            if (j > 0) tick();
            exp_en = (j >= 9) ? 4'hF : (j >= 6) ? 4'h7 : (j >= 3) ? 4'h3 : 4'h1;
            chk($sformatf("ramp_en_%0d", j), en_a, exp_en);
        end
        done_a = 4'h0;
        rx_a = 4'b1011;
        repeat (5) tick();
        rx_a = 4'h0;
        done_a = 4'hF;
        tick();
        tick();
        tick();
        rx_a = 4'b0001;
        tick();
        rx_a = 4'h0;
        repeat (15) tick();
        chk("drain_still_open", start_a, 1'b1);
        tick();
        chk("report_start_low", start_a, 1'b0);
        chk("report_enable_low", en_a, 4'h0);
        chk("report_busy", busy_a, 1'b1);
        chk("report_cycles", cnt_a, 32'd34);
        chk("report_rx_total", rxt_a, 32'd16);
        tick();
        chk("done_finished", fin_a, 1'b1);
        chk("done_busy", busy_a, 1'b0);
        chk("done_timeout", to_a, 1'b0);
        chk("done_cycles_frozen", cnt_a, 32'd34);
        done_a = 4'h0;

        // Restart from DONE, then a go during RUN must not restart the count.
        go_a = 1'b1;
        tick();
        go_a = 1'b0;
        chk("restart_start", start_a, 1'b1);
        chk("restart_finished", fin_a, 1'b0);
        chk("restart_cycles", cnt_a, 32'd0);
        repeat (12) tick();
        go_a = 1'b1;
        tick();
        go_a = 1'b0;
        chk("go_in_run_ignored", cnt_a, 32'd13);
        done_a = 4'hF;
        begin
            int k;
            k = 0;
            while (!fin_a && k < 60) begin
                tick();
                k++;
            end
            chk("run2_finished", fin_a, 1'b1);
        end
        done_a = 4'h0;

        // Asynchronous reset in the middle of a ramp.
        go_a = 1'b1;
        tick();
        go_a = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_start", start_a, 1'b0);
        chk("arst_enable", en_a, 4'h0);
        chk("arst_busy", busy_a, 1'b0);
        chk("arst_finished", fin_a, 1'b0);
        chk("arst_timeout", to_a, 1'b0);
        chk("arst_cycles", cnt_a, 32'd0);
        chk("arst_rx_total", rxt_a, 32'd0);
        chk("arst_b_finished", fin_b, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_after_rst", busy_a, 1'b0);
        go_a = 1'b1;
        tick();
        go_a = 1'b0;
        chk("go_from_idle", start_a, 1'b1);

        // Randomized traffic on instance A against the model.
        for (int i = 0; i < 1500; i++) begin
            go_a   = ($urandom_range(0, 15) == 0);
            done_a = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            rx_a   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            tick();
        end
        go_a = 1'b0; done_a = 4'h0; rx_a = 4'h0;

        // Instance B: done never arrives.
        go_b = 1'b1;
        tick();
        go_b = 1'b0;
`ifdef NOC_SEQ_WATCHDOG_EN
        begin
            int k;
            k = 0;
            while (start_b && k < 200) begin
                tick();
                k++;
            end
            chk("wd_edges", k, 50);
            chk("wd_start_low", start_b, 1'b0);
            chk("wd_cycles", cnt_b, 32'd49);
            chk("wd_timeout", to_b, 1'b1);
            tick();
            chk("wd_finished", fin_b, 1'b1);
            chk("wd_timeout_held", to_b, 1'b1);
        end
`else
        repeat (1000) tick();
        chk("nowd_start", start_b, 1'b1);
        chk("nowd_busy", busy_b, 1'b1);
        chk("nowd_timeout", to_b, 1'b0);
        chk("nowd_cycles", cnt_b, 32'd1000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
